// File: rtl/link_queue_ctrl_if.sv
// Push/pop handshake and node-RAM bus of link_queue_ctrl.
// The controller connects through the slave modport; the traffic source and RAM connect through master.
interface link_queue_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                             push_valid;
  logic [DATA_WIDTH-1:0]            push_data;
  logic                             push_ready;
  logic                             pop_valid;
  logic                             pop_ready;
  logic [DATA_WIDTH-1:0]            pop_data;
  logic                             pop_data_valid;
  logic                             ram_write_req;
  logic [ADDR_WIDTH-1:0]            ram_addr;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] ram_write_data;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] ram_read_data;

  modport slave (
    input  push_valid, push_data, pop_valid, ram_read_data,
    output push_ready, pop_ready, pop_data, pop_data_valid,
           ram_write_req, ram_addr, ram_write_data
  );

  modport master (
    output push_valid, push_data, pop_valid, ram_read_data,
    input  push_ready, pop_ready, pop_data, pop_data_valid,
           ram_write_req, ram_addr, ram_write_data
  );
endinterface

// File: rtl/link_queue_ctrl.sv
// Linked-list FIFO controller: builds a free list in a single-port node RAM, then serves push/pop.
// Define LINK_QUEUE_ERR_EN to add sticky err_overflow / err_underflow outputs.
module link_queue_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  link_queue_ctrl_if.slave    bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                empty,
  output logic                full,
  output logic                init_done
`ifdef LINK_QUEUE_ERR_EN
  ,
  output logic                err_overflow,
  output logic                err_underflow
`endif
);

  localparam int DEPTH      = 32'd1 << ADDR_WIDTH;
  localparam int WORD_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_INIT      = 3'd1,
    ST_IDLE      = 3'd2,
    ST_RD        = 3'd3,
    ST_PUSH_NODE = 3'd4,
    ST_PUSH_LINK = 3'd5,
    ST_POP_FREE  = 3'd6
  } state_t;

  function automatic logic [WORD_WIDTH-1:0] pack_node(
    input logic [ADDR_WIDTH-1:0] next,
    input logic [DATA_WIDTH-1:0] payload
  );
    return {next, payload};
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   init_idx_q, init_idx_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d;
  logic [ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [ADDR_WIDTH-1:0] free_head_q, free_head_d;
  logic [ADDR_WIDTH-1:0] new_node_q, new_node_d;
  logic [DATA_WIDTH-1:0] tail_data_q, tail_data_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  op_pop_q, op_pop_d;
  logic                  pop_data_valid_q, pop_data_valid_d;
  logic                  init_done_q, init_done_d;
`ifdef LINK_QUEUE_ERR_EN
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_underflow_q, err_underflow_d;
`endif

  logic                  idle_s, empty_s, full_s;
  logic                  push_ready_s, pop_ready_s, push_fire_s, pop_fire_s;
  logic [ADDR_WIDTH-1:0] rd_next_s;
  logic [DATA_WIDTH-1:0] rd_payload_s;
  logic                  ram_write_req_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic [WORD_WIDTH-1:0] ram_write_data_s;

  assign idle_s       = (state_q == ST_IDLE);
  assign empty_s      = (count_q == {(ADDR_WIDTH+1){1'b0}});
  assign full_s       = (count_q == DEPTH_CNT);
  assign rd_next_s    = bus.ram_read_data[WORD_WIDTH-1:DATA_WIDTH];
  assign rd_payload_s = bus.ram_read_data[DATA_WIDTH-1:0];

  // A pending pop blocks the push so that the pop is always served first.
  assign pop_ready_s  = idle_s && !empty_s;
  assign push_ready_s = idle_s && !full_s && !(bus.pop_valid && !empty_s);
  assign pop_fire_s   = bus.pop_valid && pop_ready_s;
  assign push_fire_s  = bus.push_valid && push_ready_s;

  // Next-state and register update for the list controller.
  always_comb begin
    state_d          = state_q;
    init_idx_d       = init_idx_q;
    head_d           = head_q;
    tail_d           = tail_q;
    free_head_d      = free_head_q;
    new_node_d       = new_node_q;
    tail_data_d      = tail_data_q;
    data_d           = data_q;
    pop_data_d       = pop_data_q;
    count_d          = count_q;
    op_pop_d         = op_pop_q;
    pop_data_valid_d = 1'b0;
    init_done_d      = init_done_q;
`ifdef LINK_QUEUE_ERR_EN
    err_overflow_d   = err_overflow_q;
    err_underflow_d  = err_underflow_q;
`endif
    case (state_q)
      ST_RST: begin
        init_idx_d = {(ADDR_WIDTH+1){1'b0}};
        state_d    = ST_INIT;
      end
      ST_INIT: begin
        // One extra cycle after the last node write publishes the free list.
        if (init_idx_q == DEPTH_CNT) begin
          free_head_d = {ADDR_WIDTH{1'b0}};
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          init_idx_d = init_idx_q + (ADDR_WIDTH+1)'(1'b1);
        end
      end
      ST_IDLE: begin
        if (pop_fire_s) begin
          op_pop_d = 1'b1;
          state_d  = ST_RD;
        end else if (push_fire_s) begin
          op_pop_d = 1'b0;
          data_d   = bus.push_data;
          state_d  = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
`ifdef LINK_QUEUE_ERR_EN
        if (bus.push_valid && full_s) begin
          err_overflow_d = 1'b1;
        end else begin
          err_overflow_d = err_overflow_q;
        end
        if (bus.pop_valid && empty_s) begin
          err_underflow_d = 1'b1;
        end else begin
          err_underflow_d = err_underflow_q;
        end
`endif
      end
      ST_RD: begin
        if (op_pop_q) begin
          state_d = ST_POP_FREE;
        end else begin
          state_d = ST_PUSH_NODE;
        end
      end
      ST_PUSH_NODE: begin
        new_node_d  = free_head_q;
        free_head_d = rd_next_s;
        if (empty_s) begin
          head_d      = free_head_q;
          tail_d      = free_head_q;
          tail_data_d = data_q;
          count_d     = count_q + (ADDR_WIDTH+1)'(1'b1);
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_PUSH_LINK;
        end
      end
      ST_PUSH_LINK: begin
        tail_d      = new_node_q;
        tail_data_d = data_q;
        count_d     = count_q + (ADDR_WIDTH+1)'(1'b1);
        state_d     = ST_IDLE;
      end
      ST_POP_FREE: begin
        pop_data_d       = rd_payload_s;
        pop_data_valid_d = 1'b1;
        head_d           = rd_next_s;
        free_head_d      = head_q;
        count_d          = count_q - (ADDR_WIDTH+1)'(1'b1);
        state_d          = ST_IDLE;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  // RAM request decode: the address and word follow directly from state and pointers.
  always_comb begin
    ram_write_req_s  = 1'b0;
    ram_addr_s       = {ADDR_WIDTH{1'b0}};
    ram_write_data_s = {WORD_WIDTH{1'b0}};
    case (state_q)
      ST_INIT: begin
        if (init_idx_q != DEPTH_CNT) begin
          ram_write_req_s  = 1'b1;
          ram_addr_s       = init_idx_q[ADDR_WIDTH-1:0];
          ram_write_data_s = pack_node(init_idx_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1'b1),
                                       {DATA_WIDTH{1'b0}});
        end else begin
          ram_write_req_s = 1'b0;
        end
      end
      ST_RD: begin
        if (op_pop_q) begin
          ram_addr_s = head_q;
        end else begin
          ram_addr_s = free_head_q;
        end
      end
      ST_PUSH_NODE: begin
        ram_write_req_s  = 1'b1;
        ram_addr_s       = free_head_q;
        ram_write_data_s = pack_node({ADDR_WIDTH{1'b0}}, data_q);
      end
      ST_PUSH_LINK: begin
        ram_write_req_s  = 1'b1;
        ram_addr_s       = tail_q;
        ram_write_data_s = pack_node(new_node_q, tail_data_q);
      end
      ST_POP_FREE: begin
        ram_write_req_s  = 1'b1;
        ram_addr_s       = head_q;
        ram_write_data_s = pack_node(free_head_q, {DATA_WIDTH{1'b0}});
      end
      default: begin
        ram_write_req_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RST;
      init_idx_q       <= {(ADDR_WIDTH+1){1'b0}};
      head_q           <= {ADDR_WIDTH{1'b0}};
      tail_q           <= {ADDR_WIDTH{1'b0}};
      free_head_q      <= {ADDR_WIDTH{1'b0}};
      new_node_q       <= {ADDR_WIDTH{1'b0}};
      tail_data_q      <= {DATA_WIDTH{1'b0}};
      data_q           <= {DATA_WIDTH{1'b0}};
      pop_data_q       <= {DATA_WIDTH{1'b0}};
      count_q          <= {(ADDR_WIDTH+1){1'b0}};
      op_pop_q         <= 1'b0;
      pop_data_valid_q <= 1'b0;
      init_done_q      <= 1'b0;
`ifdef LINK_QUEUE_ERR_EN
      err_overflow_q   <= 1'b0;
      err_underflow_q  <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      init_idx_q       <= init_idx_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      free_head_q      <= free_head_d;
      new_node_q       <= new_node_d;
      tail_data_q      <= tail_data_d;
      data_q           <= data_d;
      pop_data_q       <= pop_data_d;
      count_q          <= count_d;
      op_pop_q         <= op_pop_d;
      pop_data_valid_q <= pop_data_valid_d;
      init_done_q      <= init_done_d;
`ifdef LINK_QUEUE_ERR_EN
      err_overflow_q   <= err_overflow_d;
      err_underflow_q  <= err_underflow_d;
`endif
    end
  end

  assign bus.push_ready     = push_ready_s;
  assign bus.pop_ready      = pop_ready_s;
  assign bus.pop_data       = pop_data_q;
  assign bus.pop_data_valid = pop_data_valid_q;
  assign bus.ram_write_req  = ram_write_req_s;
  assign bus.ram_addr       = ram_addr_s;
  assign bus.ram_write_data = ram_write_data_s;
  assign count              = count_q;
  assign empty              = empty_s;
  assign full               = full_s;
  assign init_done          = init_done_q;
`ifdef LINK_QUEUE_ERR_EN
  assign err_overflow       = err_overflow_q;
  assign err_underflow      = err_underflow_q;
`endif

endmodule

// File: tb/tb_link_queue_ctrl.sv
// Self-checking bench for link_queue_ctrl: models the node RAM and compares
// popped data and occupancy against a reference FIFO queue.
module tb_link_queue_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int WW    = AW + DW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  link_queue_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  logic [AW:0] count;
  logic        empty, full, init_done;
`ifdef LINK_QUEUE_ERR_EN
  logic        err_overflow, err_underflow;
`endif

  link_queue_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .init_done (init_done)
`ifdef LINK_QUEUE_ERR_EN
    ,
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`endif
  );

  // Single-port RAM: read word appears the cycle after the address.
  logic [WW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_write_req === 1'b1) mem[bus.ram_addr] <= bus.ram_write_data;
    bus.ram_read_data <= mem[bus.ram_addr];
  end

  logic [DW-1:0] model_q [$];
  int checks   = 0;
  int failures = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic settle();
    repeat (3) begin @(negedge clk); #1; end
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    int n;
    @(negedge clk); bus.push_valid = 1'b1; bus.push_data = d; #1;
    n = 0;
    while (bus.push_ready !== 1'b1 && n < 64) begin @(negedge clk); #1; n++; end
    if (n >= 64) begin
      checks++; failures++;
      $display("FAIL push_accept_timeout data=%h", d);
    end
    @(negedge clk); bus.push_valid = 1'b0; #1;
    model_q.push_back(d);
  endtask

  task automatic do_pop(input string tag);
    int n;
    logic [DW-1:0] exp;
    @(negedge clk); bus.pop_valid = 1'b1; #1;
    n = 0;
    while (bus.pop_ready !== 1'b1 && n < 64) begin @(negedge clk); #1; n++; end
    if (n >= 64) begin
      checks++; failures++;
      $display("FAIL %s pop_accept_timeout", tag);
    end
    @(negedge clk); bus.pop_valid = 1'b0; #1;
    n = 0;
    while (bus.pop_data_valid !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
    exp = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
    checks++;
    if (n != 2) begin
      failures++; $display("FAIL %s pop_latency got=%0d exp=2 (cycles after RD)", tag, n);
    end
    checks++;
    if (bus.pop_data !== exp) begin
      failures++; $display("FAIL %s pop_data got=%h exp=%h", tag, bus.pop_data, exp);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.pop_data_valid !== 1'b0 || bus.pop_data !== exp) begin
      failures++;
      $display("FAIL %s pop_pulse valid=%b data=%h exp valid=0 data=%h", tag,
               bus.pop_data_valid, bus.pop_data, exp);
    end
  endtask

  task automatic test_reset();
    int n;
    bus.push_valid = 1'b0; bus.push_data = 8'h00; bus.pop_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({bus.push_ready, bus.pop_ready, bus.pop_data_valid, full, init_done,
         bus.ram_write_req, empty} !== 7'b0000001) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000001", {bus.push_ready, bus.pop_ready,
               bus.pop_data_valid, full, init_done, bus.ram_write_req, empty});
    end
    checks++;
    if (count !== 5'd0 || bus.pop_data !== 8'h00 || bus.ram_addr !== 4'd0 ||
        bus.ram_write_data !== 12'h000) begin
      failures++;
      $display("FAIL reset_values count=%0d pop_data=%h addr=%h wdata=%h exp all 0",
               count, bus.pop_data, bus.ram_addr, bus.ram_write_data);
    end
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 18) begin
      failures++; $display("FAIL init_latency got=%0d exp=18", n);
    end
    checks++;
    if (mem[15] !== 12'h000) begin
      failures++; $display("FAIL init_node15 got=%h exp=000", mem[15]);
    end
    checks++;
    if (mem[3] !== 12'h400) begin
      failures++; $display("FAIL init_node3 got=%h exp=400", mem[3]);
    end
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      failures++; $display("FAIL init_count count=%0d empty=%b exp 0/1", count, empty);
    end
  endtask

  task automatic test_basic();
    @(negedge clk); bus.push_valid = 1'b1; bus.push_data = 8'h11; #1;
    checks++;
    if (bus.push_ready !== 1'b1) begin
      failures++; $display("FAIL push_ready_idle got=%b exp=1", bus.push_ready);
    end
    @(negedge clk); bus.push_valid = 1'b0; #1;
    checks++;
    if ({bus.ram_write_req, bus.ram_addr} !== 5'h00) begin
      failures++; $display("FAIL push1_rd got=%b_%h exp=0_0", bus.ram_write_req, bus.ram_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.ram_write_req, bus.ram_addr, bus.ram_write_data} !== {1'b1, 4'h0, 12'h011}) begin
      failures++; $display("FAIL push1_node got=%b_%h_%h exp=1_0_011",
                           bus.ram_write_req, bus.ram_addr, bus.ram_write_data);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.push_ready !== 1'b1 || count !== 5'd1) begin
      failures++; $display("FAIL push1_done ready=%b count=%0d exp 1/1", bus.push_ready, count);
    end
    model_q.push_back(8'h11);
    bus.push_valid = 1'b1; bus.push_data = 8'h22;
    @(negedge clk); bus.push_valid = 1'b0; #1;
    checks++;
    if ({bus.ram_write_req, bus.ram_addr} !== 5'h01) begin
      failures++; $display("FAIL push2_rd got=%b_%h exp=0_1", bus.ram_write_req, bus.ram_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.ram_write_req, bus.ram_addr, bus.ram_write_data} !== {1'b1, 4'h1, 12'h022}) begin
      failures++; $display("FAIL push2_node got=%b_%h_%h exp=1_1_022",
                           bus.ram_write_req, bus.ram_addr, bus.ram_write_data);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.ram_write_req, bus.ram_addr, bus.ram_write_data, bus.push_ready} !==
        {1'b1, 4'h0, 12'h111, 1'b0}) begin
      failures++; $display("FAIL push2_link got=%b_%h_%h ready=%b exp=1_0_111 ready=0",
                           bus.ram_write_req, bus.ram_addr, bus.ram_write_data, bus.push_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.push_ready !== 1'b1 || count !== 5'd2) begin
      failures++; $display("FAIL push2_done ready=%b count=%0d exp 1/2", bus.push_ready, count);
    end
    model_q.push_back(8'h22);
    do_push(8'h33);
    repeat (3) do_pop("basic");
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      failures++; $display("FAIL basic_empty empty=%b count=%0d exp 1/0", empty, count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) do_push(8'($urandom_range(0, 255)));
    settle();
    checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      failures++; $display("FAIL fill_full full=%b count=%0d exp 1/16", full, count);
    end
    @(negedge clk); bus.push_valid = 1'b1; bus.push_data = 8'hEE; #1;
    checks++;
    if (bus.push_ready !== 1'b0) begin
      failures++; $display("FAIL push_ready_at_full got=%b exp=0", bus.push_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (count !== 5'd16 || bus.push_ready !== 1'b0) begin
      failures++; $display("FAIL full_stall count=%0d ready=%b exp 16/0", count, bus.push_ready);
    end
`ifdef LINK_QUEUE_ERR_EN
    checks++;
    if (err_overflow !== 1'b1 || err_underflow !== 1'b0) begin
      failures++; $display("FAIL err_overflow got=%b/%b exp=1/0", err_overflow, err_underflow);
    end
`endif
    bus.push_valid = 1'b0;
    do_pop("fill");
    do_push(8'hC3);
    settle();
    checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      failures++; $display("FAIL refill_full full=%b count=%0d exp 1/16", full, count);
    end
    repeat (DEPTH) do_pop("drain");
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL drain_empty got=%b exp=1", empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    do_push(8'hA0);
    do_push(8'hA1);
    settle();
    @(negedge clk); bus.pop_valid = 1'b1; bus.push_valid = 1'b1; bus.push_data = 8'hA2; #1;
    checks++;
    if (bus.pop_ready !== 1'b1 || bus.push_ready !== 1'b0) begin
      failures++; $display("FAIL arb_ready pop=%b push=%b exp 1/0", bus.pop_ready, bus.push_ready);
    end
    @(negedge clk); bus.pop_valid = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (bus.pop_data_valid !== 1'b0 || bus.push_ready !== 1'b0) begin
      failures++; $display("FAIL arb_t2 pdv=%b push_ready=%b exp 0/0",
                           bus.pop_data_valid, bus.push_ready);
    end
    @(negedge clk); #1;
    exp = model_q.pop_front();
    checks++;
    if (bus.pop_data_valid !== 1'b1 || bus.pop_data !== exp || bus.push_ready !== 1'b1) begin
      failures++; $display("FAIL arb_t3 pdv=%b data=%h push_ready=%b exp 1/%h/1",
                           bus.pop_data_valid, bus.pop_data, bus.push_ready, exp);
    end
    @(negedge clk); bus.push_valid = 1'b0; #1;
    model_q.push_back(8'hA2);
    settle();
    checks++;
    if (count !== 5'd2) begin
      failures++; $display("FAIL arb_count got=%0d exp=2", count);
    end
    repeat (2) do_pop("arb");
  endtask

  task automatic test_random();
    int pushes;
    pushes = 0;
    while (pushes < 40 || model_q.size() > 0) begin
      if (pushes < 40 && model_q.size() < DEPTH &&
          (model_q.size() == 0 || $urandom_range(0, 2) != 0)) begin
        do_push(8'($urandom_range(0, 255)));
        pushes++;
      end else begin
        do_pop("rand");
      end
      settle();
      checks++;
      if (count !== 5'(model_q.size()) || count > 5'd16) begin
        failures++; $display("FAIL rand_count got=%0d exp=%0d", count, model_q.size());
      end
    end
  endtask

  task automatic test_reset_midop();
    int n;
    do_push(8'h01);
    settle();
    @(negedge clk); bus.push_valid = 1'b1; bus.push_data = 8'h02; #1;
    checks++;
    if (bus.push_ready !== 1'b1) begin
      failures++; $display("FAIL midop_accept got=%b exp=1", bus.push_ready);
    end
    @(negedge clk); bus.push_valid = 1'b0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (bus.ram_write_req !== 1'b1 || bus.ram_write_data[DW-1:0] !== 8'h01) begin
      failures++; $display("FAIL midop_link req=%b payload=%h exp 1/01",
                           bus.ram_write_req, bus.ram_write_data[DW-1:0]);
    end
    rst_n = 1'b0; #1;
    model_q.delete();
    checks++;
    if ({bus.push_ready, bus.pop_ready, bus.pop_data_valid, full, init_done,
         bus.ram_write_req, empty} !== 7'b0000001 || count !== 5'd0 ||
        bus.pop_data !== 8'h00 || bus.ram_addr !== 4'd0 || bus.ram_write_data !== 12'h000) begin
      failures++;
      $display("FAIL midop_reset flags=%b count=%0d data=%h addr=%h wdata=%h exp 0000001/0/0/0/0",
               {bus.push_ready, bus.pop_ready, bus.pop_data_valid, full, init_done,
                bus.ram_write_req, empty}, count, bus.pop_data, bus.ram_addr, bus.ram_write_data);
    end
`ifdef LINK_QUEUE_ERR_EN
    checks++;
    if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      failures++; $display("FAIL midop_err_reset got=%b/%b exp=0/0", err_overflow, err_underflow);
    end
`endif
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (init_done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 18) begin
      failures++; $display("FAIL reinit_latency got=%0d exp=18", n);
    end
    @(negedge clk); bus.pop_valid = 1'b1; #1;
    checks++;
    if (bus.pop_ready !== 1'b0 || empty !== 1'b1) begin
      failures++; $display("FAIL reinit_pop_stall ready=%b empty=%b exp 0/1", bus.pop_ready, empty);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.pop_data_valid !== 1'b0 || count !== 5'd0) begin
      failures++; $display("FAIL reinit_stall_hold pdv=%b count=%0d exp 0/0",
                           bus.pop_data_valid, count);
    end
`ifdef LINK_QUEUE_ERR_EN
    checks++;
    if (err_underflow !== 1'b1) begin
      failures++; $display("FAIL err_underflow got=%b exp=1", err_underflow);
    end
`endif
    bus.pop_valid = 1'b0;
    do_push(8'h5A);
    do_pop("reinit");
    checks++;
    if (empty !== 1'b1) begin
      failures++; $display("FAIL reinit_empty got=%b exp=1", empty);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
